// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_matrix_scanner
// Purpose  : Matrix keypad scanner. It drives one-hot column strobes and
//            synchronises the row lines. Results are debounced over whole
//            scans, and chords are rejected. A held key can auto-repeat.
//            Accepted keys leave on a one-entry valid/ready output register.
// Revision : 1.0  initial release
// ============================================================================
module keypad_matrix_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int COL_DWELL      = 524288,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_DELAY   = 16,
  parameter int REPEAT_PERIOD  = 4,
  parameter int CW             = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic [ROWS-1:0] filas_raw,
  output logic [COLS-1:0] columnas,
  output logic            key_valid,
  input  logic            key_ready,
  output logic [CW-1:0]   key_code,
  output logic            key_down,
  output logic            overflow,
  input  logic            overflow_clr
);

  localparam int c_DW  = $clog2(COL_DWELL);
  localparam int c_CIW = $clog2(COLS);
  localparam int c_RW  = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1) + 1;

  localparam logic [c_DW-1:0]  c_DWELL_LAST = c_DW'(COL_DWELL - 1);
  localparam logic [c_CIW-1:0] c_COL_LAST   = c_CIW'(COLS - 1);
  localparam logic [3:0]       c_DEB        = 4'(DEBOUNCE_SCANS);
  localparam logic [c_RW-1:0]  c_REP_FIRST  = c_RW'(REPEAT_DELAY);
  localparam logic [c_RW-1:0]  c_REP_NEXT   = c_RW'(REPEAT_DELAY + REPEAT_PERIOD);
  localparam bit               c_REP_ENA    = (REPEAT_PERIOD != 0);

  // Classification of one full scan (also used for the accepted state)
  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } res_t;

  // Synchroniser
  logic [ROWS-1:0] r_rows_m;
  logic [ROWS-1:0] r_rows_s;

  // Column strobe / dwell
  logic [c_DW-1:0]  r_dwell;
  logic             w_sample;
  logic             w_onehot;
  logic [c_CIW-1:0] w_col_idx;
  logic             w_eos;

  // Per-scan accumulation
  logic [1:0]    r_pts;
  logic [CW-1:0] r_first;
  logic [1:0]    w_cnt;
  logic [CW-1:0] w_code;

  // Debounce / accepted state / repeat
  res_t            r_prev_kind;
  logic [CW-1:0]   r_prev_code;
  logic [3:0]      r_stab;
  res_t            r_acc_kind;
  logic [CW-1:0]   r_acc_code;
  logic [c_RW-1:0] r_rep;
  res_t            w_res_kind;
  logic            w_same;
  logic [3:0]      w_stab_nxt;
  logic            w_accept;
  logic            w_new_key;
  logic [c_RW-1:0] w_rep_inc;
  logic            w_rep_fire;

  // Event strobe towards the output register
  logic          r_evt;
  logic [CW-1:0] r_evt_code;

  // Two-flop synchroniser on the asynchronous row lines
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_rows_m <= '0;
      r_rows_s <= '0;
    end else begin
      r_rows_m <= filas_raw;
      r_rows_s <= r_rows_m;
    end
  end

  assign w_sample = (r_dwell == c_DWELL_LAST);
  assign w_onehot = (columnas != '0) && ((columnas & (columnas - COLS'(1))) == '0);

  // Column FSM: dwell counter, rotate strobe on wrap, recover a corrupt strobe
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_dwell  <= '0;
      columnas <= COLS'(1);
    end else if (w_sample) begin
      r_dwell  <= '0;
      columnas <= w_onehot ? {columnas[COLS-2:0], columnas[COLS-1]} : COLS'(1);
    end else begin
      r_dwell  <= r_dwell + c_DW'(1);
    end
  end

  // Current column index plus this column's contribution to the scan tally
  always_comb begin
    w_col_idx = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (columnas[c]) w_col_idx = c_CIW'(c);
    end
    // Column 0 opens a fresh scan, so earlier tallies are discarded
    w_cnt  = (w_col_idx == '0) ? 2'd0 : r_pts;
    w_code = (w_col_idx == '0) ? '0   : r_first;
    for (int r = 0; r < ROWS; r++) begin
      if (r_rows_s[r]) begin
        if (w_cnt == 2'd0) w_code = CW'(r * COLS + int'(w_col_idx));
        if (w_cnt != 2'd2) w_cnt = w_cnt + 2'd1;
      end
    end
  end

  assign w_eos = w_sample && (w_col_idx == c_COL_LAST);

  // Scan classification, debounce count and repeat-counter next values
  always_comb begin
    if (w_cnt == 2'd0)      w_res_kind = RES_NONE;
    else if (w_cnt == 2'd1) w_res_kind = RES_SINGLE;
    else                    w_res_kind = RES_MULTI;

    w_same = (w_res_kind == r_prev_kind) &&
             ((w_res_kind != RES_SINGLE) || (w_code == r_prev_code));

    if (!w_same)              w_stab_nxt = 4'd1;
    else if (r_stab >= c_DEB) w_stab_nxt = c_DEB;
    else                      w_stab_nxt = r_stab + 4'd1;

    w_accept   = (w_stab_nxt == c_DEB);
    w_new_key  = (r_acc_kind != RES_SINGLE) || (r_acc_code != w_code);
    w_rep_inc  = r_rep + c_RW'(1);
    w_rep_fire = (w_rep_inc == c_REP_FIRST) || (w_rep_inc == c_REP_NEXT);
  end

  // Scan tally, debounce, accepted-state transitions and auto-repeat events
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_pts       <= '0;
      r_first     <= '0;
      r_prev_kind <= RES_NONE;
      r_prev_code <= '0;
      r_stab      <= '0;
      r_acc_kind  <= RES_NONE;
      r_acc_code  <= '0;
      r_rep       <= '0;
      key_down    <= 1'b0;
      r_evt       <= 1'b0;
      r_evt_code  <= '0;
    end else begin
      r_evt <= 1'b0;
      if (w_sample) begin
        r_pts   <= w_cnt;
        r_first <= w_code;
      end
      if (w_eos) begin
        r_prev_kind <= w_res_kind;
        r_prev_code <= w_code;
        r_stab      <= w_stab_nxt;
        if (w_accept && (w_res_kind == RES_SINGLE) && w_new_key) begin
          // New single key: press event, restart repeat timing
          r_acc_kind <= RES_SINGLE;
          r_acc_code <= w_code;
          key_down   <= 1'b1;
          r_rep      <= '0;
          r_evt      <= 1'b1;
          r_evt_code <= w_code;
        end else if (w_accept && (w_res_kind != RES_SINGLE)) begin
          // Release or chord: silent, but remembered so a later single re-presses
          r_acc_kind <= w_res_kind;
          key_down   <= 1'b0;
          r_rep      <= '0;
        end else if (c_REP_ENA && (r_acc_kind == RES_SINGLE)) begin
          // Counter folds back to the first-repeat point to keep the period
          r_rep <= (w_rep_inc == c_REP_NEXT) ? c_REP_FIRST : w_rep_inc;
          if (w_rep_fire) begin
            r_evt      <= 1'b1;
            r_evt_code <= r_acc_code;
          end
        end
      end
    end
  end

  // One-entry output register with drop-and-flag on backpressure
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (r_evt && (!key_valid || key_ready)) begin
        key_valid <= 1'b1;
        key_code  <= r_evt_code;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
      if (r_evt && key_valid && !key_ready) overflow <= 1'b1;
      else if (overflow_clr)                overflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire
